shift_sequencer: RTL and testbench

//  Multi-cycle shift controller for the execute stage. Latches a 16-bit operand, a
//  4-bit amount and a shift op, then steps an internal shift-by-1/shift-by-2 stage

---
 rtl/shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_shift_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: latches operand/amount/op, applies 2-bit then 1-bit steps until the amount is consumed.
// Latency: done pulses ceil(Cnt/2)+1 cycles after the start cycle (Cnt=0 -> next cycle); Out registered on DONE entry.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted with no bubble.
// Build option: define SHIFT_SEQ_ROTATE_EN to enable rotate-right on Op=11 (otherwise Op=11 behaves as SRL).
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_nxt;
    logic [CNT_W-1:0] step_amt;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             accept;
    logic             two_step;

    // A request is taken whenever no shift is in flight (IDLE or the done cycle)
    assign accept   = start && (state_q != S_SHIFT);
    assign two_step = (rem_q >= CNT_W'(2));
    assign step_amt = two_step ? CNT_W'(2) : CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: zero-amount requests go straight to DONE
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = (Cnt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                state_nxt = (rem_nxt == '0) ? S_DONE : S_SHIFT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: busy only while stepping, done only in the single DONE cycle
    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
    end

    // One shift step of the accumulator; SRA fills from the sign captured at start
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL: acc_step = two_step ? {acc_q[WIDTH-3:0], 2'b00}
                                        : {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL: acc_step = two_step ? {2'b00, acc_q[WIDTH-1:2]}
                                        : {1'b0, acc_q[WIDTH-1:1]};
            OP_SRA: acc_step = two_step ? {{2{sign_q}}, acc_q[WIDTH-1:2]}
                                        : {sign_q, acc_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR: acc_step = two_step ? {acc_q[1:0], acc_q[WIDTH-1:2]}
                                        : {acc_q[0], acc_q[WIDTH-1:1]};
`endif
            // Op=11 without the rotate option falls back to a logical right shift
            default: acc_step = two_step ? {2'b00, acc_q[WIDTH-1:2]}
                                         : {1'b0, acc_q[WIDTH-1:1]};
        endcase
    end

    // Next accumulator and remaining count: load on accept, step while shifting, else hold
    always_comb begin
        acc_nxt = acc_q;
        rem_nxt = rem_q;
        if (accept) begin
            acc_nxt = In;
            rem_nxt = Cnt;
        end else if (state_q == S_SHIFT) begin
            acc_nxt = acc_step;
            rem_nxt = rem_q - step_amt;
        end
    end

    // Operand/amount/op storage; inputs are only looked at on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            rem_q  <= '0;
            op_q   <= OP_SLL;
            sign_q <= 1'b0;
        end else begin
            acc_q <= acc_nxt;
            rem_q <= rem_nxt;
            if (accept) begin
                op_q   <= Op;
                sign_q <= In[WIDTH-1];
            end
        end
    end

    // Result register: written only on entry to DONE so intermediate steps never show
    always_ff @(posedge clk) begin
        if (rst) begin
            Out <= '0;
        end else if (state_nxt == S_DONE) begin
            Out <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver predicts result and done cycle per accepted request,
// the monitor compares done/busy/Out every cycle on the falling edge.
// Reference model is plain arithmetic shifts; SHIFT_SEQ_ROTATE_EN selects the Op=11 meaning.
module tb_shift_sequencer;

    typedef struct {
        logic [15:0] res;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [3:0]  a_cnt;
    logic [1:0]  a_op;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last_out = 16'h0;
    exp_t        q[$];

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (a_in),
        .Cnt   (a_cnt),
        .Op    (a_op),
        .Out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] v, input int n);
        logic [31:0] w;
        logic [15:0] r;
        w = {v, v} >> n;
        case (op)
            2'b00:   r = v << n;
            2'b01:   r = v >> n;
            2'b10:   r = $signed(v) >>> n;
`ifdef SHIFT_SEQ_ROTATE_EN
            default: r = w[15:0];
`else
            default: r = v >> n;
`endif
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; a start is predicted as accepted only when no request is outstanding
    // or the outstanding one finishes in this very cycle.
    task automatic step(input logic s, input logic [1:0] op, input logic [15:0] v, input logic [3:0] n);
        exp_t e;
        start = s;
        a_op  = op;
        a_in  = v;
        a_cnt = n;
        if (s && (q.size() == 0 || cyc >= q[$].done_cyc)) begin
            e.res       = ref_shift(op, v, int'(n));
            e.start_cyc = cyc;
            e.done_cyc  = cyc + (int'(n) + 1) / 2 + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 16'($urandom);
        a_cnt = 4'($urandom);
        a_op  = 2'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'($urandom), 16'($urandom), 4'($urandom));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            idle(1);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle at cycle %0d: %0d requests outstanding, required 0", cyc, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        last_out = 16'h0;
    endtask

    // Monitor: done must pulse exactly in the predicted cycle, busy strictly between start and done,
    // and Out must always show the most recent completed result
    initial begin
        exp_t e;
        logic exp_done;
        logic exp_busy;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_done = (q.size() != 0) && (cyc == q[0].done_cyc);
                chk("done", 32'(done), 32'(exp_done));
                if (exp_done) begin
                    e = q.pop_front();
                    if (done) chk("out_result", 32'(out), 32'(e.res));
                    last_out = e.res;
                end
                exp_busy = (q.size() != 0) && (cyc > q[0].start_cyc) && (cyc < q[0].done_cyc);
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("out_hold", 32'(out), 32'(last_out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 16'h0;
        a_cnt = 4'h0;
        a_op  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        mon_en = 1'b1;
        idle(2);

        // SRL 8001 by 5
        step(1'b1, 2'b01, 16'h8001, 4'd5);
        wait_idle();
        chk("srl_8001_5", 32'(out), 32'h0400);
        // SRA 8000 by 15
        step(1'b1, 2'b10, 16'h8000, 4'd15);
        wait_idle();
        chk("sra_8000_15", 32'(out), 32'hFFFF);
        // SLL by 0
        step(1'b1, 2'b00, 16'h00FF, 4'd0);
        wait_idle();
        chk("sll_cnt0", 32'(out), 32'h00FF);
        // ROR / fallback
        step(1'b1, 2'b11, 16'h0001, 4'd4);
        wait_idle();
`ifdef SHIFT_SEQ_ROTATE_EN
        chk("ror_0001_4", 32'(out), 32'h1000);
`else
        chk("ror_as_srl", 32'(out), 32'h0000);
`endif
        idle(1);
        // Start while busy is ignored
        step(1'b1, 2'b01, 16'hF000, 4'd8);
        step(1'b0, 2'b00, 16'h0000, 4'd0);
        step(1'b1, 2'b01, 16'h1234, 4'd3);
        wait_idle();
        chk("busy_start_ignored", 32'(out), 32'h00F0);
        // Reset in the middle of a shift
        step(1'b1, 2'b00, 16'hABCD, 4'd12);
        idle(2);
        do_reset();
        chk("rst_mid_out", 32'(out), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        idle(2);
        // Back-to-back start in the done cycle
        step(1'b1, 2'b00, 16'h0001, 4'd2);
        step(1'b0, 2'b00, 16'h0000, 4'd0);
        step(1'b1, 2'b00, 16'h0003, 4'd1);
        chk("b2b_first_out", 32'(out), 32'h0004);
        wait_idle();
        chk("b2b_second_out", 32'(out), 32'h0006);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0) do_reset();
            else step(r < 18, 2'($urandom), 16'($urandom), 4'($urandom));
        end
        wait_idle();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
